pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RISC-V pipeline.
- Drives hold/bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sources of control: load-use hazards, taken branches/jumps resolved in EX, and a multicycle data-memory (DRAM) req/ack handshake in MEM.
- Owns the memory-wait state machine and a timeout watchdog.

Parameters:
REG_W, 5, register index width (matches WIDTH_REGMARK)
TIMEOUT, 255, max MEM_WAIT cycles before error; legal 1..2^TO_W-1
TO_W, 8, wait counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_rs1  in  REG_W  ID-stage source 1 index
id_rs2  in  REG_W  ID-stage source 2 index
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_W  EX-stage destination (RegWr)
ex_is_load  in  1  EX instruction is a load (RWSel selects DRAM)
ex_branch_taken  in  1  EX resolved redirect (branch taken or jump)
mem_access  in  1  MEM-stage instruction performs DRAM load/store
dram_ack  in  1  DRAM completes current access this cycle
dram_req  out  1  DRAM request strobe
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
stall_ex  out  1  hold ID/EX
stall_mem  out  1  hold EX/MEM
flush_id  out  1  bubble into IF/ID
flush_ex  out  1  bubble into ID/EX
flush_wb  out  1  bubble into MEM/WB (RegWe=0)
mem_err  out  1  sticky DRAM timeout flag

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk.
- While rst_n low: state=RUN, wait counter=0, mem_err=0, all outputs 0.
- Reset asserted mid-wait aborts the access. dram_req drops immediately (asynchronous).
- State register: RUN, MEM_WAIT, ERR. Outputs are combinational from state and inputs.
- RUN, memory:
  - dram_req = mem_access.
  - If mem_access && !dram_ack: assert stall_if/id/ex/mem and flush_wb; next state MEM_WAIT, counter=1.
  - If mem_access && dram_ack: single-cycle access, no stall.
- RUN, branch: if not memory-stalled and ex_branch_taken, assert flush_id and flush_ex. No stall.
- RUN, load-use: if not memory-stalled, not branch, ex_is_load, ex_rd!=0, and (id_use_rs1 && id_rs1==ex_rd || id_use_rs2 && id_rs2==ex_rd):
  - assert stall_if, stall_id and flush_ex for exactly one cycle;
  - next cycle ex_is_load has left EX, so the hazard clears naturally.
- Priority: memory stall > branch flush > load-use.
  - Branch beats load-use because the ID instruction is squashed anyway.
  - A branch in EX during a memory stall stays frozen and is acted on the cycle after release.
- MEM_WAIT:
  - dram_req=1; stall_if/id/ex/mem=1; flush_wb=1; branch and load-use outputs suppressed.
  - On dram_ack: this cycle still stalls; next state RUN. The next cycle MEM/WB captures the access result.
  - Else counter increments. When counter==TIMEOUT and no ack: next state ERR, mem_err set.
  - Counter saturates and never wraps.
- ERR: dram_req=0, all stalls=1, flush_wb=1, mem_err=1. Leaves only via reset.
- Ack in RUN without mem_access is ignored.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- When defined, adds outputs:
  - perf_mem_stall (32 bits): counts cycles in MEM_WAIT/ERR plus RUN entry-stall cycles;
  - perf_flush (32 bits): counts cycles with flush_ex due to a branch;
  - perf_lu_stall (32 bits): counts load-use stall cycles.
- Counters are reset to 0, saturate at all-ones, and are readable combinationally.
- When undefined, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of stall_if=stall_id=flush_ex=1; no stall_mem. With ex_rd=0 -> no stall.
- Branch: ex_branch_taken=1 together with a load-use match -> flush_id=flush_ex=1, stall_if=0.
- DRAM 3-cycle wait: mem_access=1, ack arrives 3rd cycle after request -> dram_req high and all stalls high for 3 cycles, flush_wb high for 3 cycles, RUN next.
- Single-cycle ack: mem_access=1, dram_ack=1 same cycle -> no stall, dram_req for one cycle.
- Timeout: TIMEOUT=4, never ack -> ERR after 4 wait cycles, mem_err=1, stalls stay high, dram_req=0; only rst_n clears.
- Reset mid-wait: rst_n low during MEM_WAIT -> all outputs 0 immediately; after release state is RUN, counter=0, mem_err=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler for the 5-stage pipeline (load-use, branch redirect, DRAM wait + watchdog).
// Define PIPE_HAZARD_CTRL_PERF_EN to add saturating perf counters for mem stalls, branch flushes and load-use stalls.
module pipe_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dram_ack,
    output logic             dram_req,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_wb,
    output logic             mem_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_mem_stall,
    output logic [31:0]      perf_flush,
    output logic [31:0]      perf_lu_stall
`endif
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            lu_hit, mem_stall, br_flush, lu_stall, hold_all;

    always_comb begin
        lu_hit    = ex_is_load && (ex_rd != '0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        mem_stall = (state_q == RUN) && mem_access && !dram_ack;
        br_flush  = (state_q == RUN) && !mem_stall && ex_branch_taken;
        lu_stall  = (state_q == RUN) && !mem_stall && !ex_branch_taken && lu_hit;
        hold_all  = (state_q != RUN) || mem_stall;
        state_d   = state_q;
        cnt_d     = cnt_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    cnt_d   = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dram_ack) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == TO_W'(TIMEOUT)) begin
                    state_d = ERR;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by rst_n so an in-flight request drops the moment reset asserts.
    assign dram_req  = rst_n && ((state_q == MEM_WAIT) || (state_q == RUN && mem_access));
    assign stall_if  = rst_n && (hold_all || lu_stall);
    assign stall_id  = rst_n && (hold_all || lu_stall);
    assign stall_ex  = rst_n && hold_all;
    assign stall_mem = rst_n && hold_all;
    assign flush_id  = rst_n && br_flush;
    assign flush_ex  = rst_n && (br_flush || lu_stall);
    assign flush_wb  = rst_n && hold_all;
    assign mem_err   = rst_n && (state_q == ERR);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_mem_stall_q, perf_mem_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_lu_stall_q, perf_lu_stall_d;

    always_comb begin
        perf_mem_stall_d = perf_mem_stall_q + 32'(hold_all && perf_mem_stall_q != '1);
        perf_flush_d     = perf_flush_q + 32'(br_flush && perf_flush_q != '1);
        perf_lu_stall_d  = perf_lu_stall_q + 32'(lu_stall && perf_lu_stall_q != '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_mem_stall_q <= '0;
            perf_flush_q     <= '0;
            perf_lu_stall_q  <= '0;
        end else begin
            perf_mem_stall_q <= perf_mem_stall_d;
            perf_flush_q     <= perf_flush_d;
            perf_lu_stall_q  <= perf_lu_stall_d;
        end
    end

    assign perf_mem_stall = perf_mem_stall_q;
    assign perf_flush     = perf_flush_q;
    assign perf_lu_stall  = perf_lu_stall_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_is_load = 1'b0;
    logic       ex_branch_taken = 1'b0, mem_access = 1'b0, dram_ack = 1'b0;
    logic       dram_req, stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_id, flush_ex, flush_wb, mem_err;

    typedef struct {
        logic [8:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Expected word order: {req, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, err}
    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] LU   = 9'b011000100;
    localparam logic [8:0] BR   = 9'b000001100;
    localparam logic [8:0] REQ  = 9'b100000000;
    localparam logic [8:0] WAIT = 9'b111110010;
    localparam logic [8:0] ERRS = 9'b011110011;

    pipe_hazard_ctrl #(.REG_W(5), .TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .dram_ack(dram_ack), .dram_req(dram_req),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_wb(flush_wb), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2, input logic ld,
                        input logic br, input logic ma, input logic ack,
                        input logic [8:0] e, input string n);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; ex_is_load = ld;
        ex_branch_taken = br; mem_access = ma; dram_ack = ack;
        x.exp = e;
        x.name = n;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t       x;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                got = {dram_req, stall_if, stall_id, stall_ex, stall_mem,
                       flush_id, flush_ex, flush_wb, mem_err};
                checks++;
                if (got !== x.exp) begin
                    failures++;
                    $display("FAIL %s got=%b exp=%b", x.name, got, x.exp);
                end
            end
        end
    end

    initial begin : stim
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, "reset_hold");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "idle");
        step(1, 0, 5, 5, 0, 1, 1, 0, 0, 0, LU,   "lu_rs2");
        step(1, 0, 5, 5, 0, 1, 0, 0, 0, 0, NONE, "lu_cleared");
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, NONE, "lu_x0");
        step(1, 7, 0, 7, 1, 0, 1, 0, 0, 0, LU,   "lu_rs1");
        step(1, 7, 0, 7, 0, 0, 1, 0, 0, 0, NONE, "lu_unused");
        step(1, 0, 5, 5, 0, 1, 1, 1, 0, 0, BR,   "br_over_lu");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, REQ,  "single_ack");
        step(1, 0, 5, 5, 0, 1, 1, 1, 1, 0, WAIT, "wait_enter");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, WAIT, "wait_1");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, WAIT, "wait_ack");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR,   "br_after_release");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, "stray_ack");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAIT, "to_enter");
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAIT, $sformatf("to_wait%0d", i));
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, ERRS, "err_state");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, ERRS, "err_sticky");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, "err_reset");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "err_released");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAIT, "rw_enter");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAIT, "rw_wait");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, "rw_async_reset");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "rw_released");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAIT, "rw2_enter");
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAIT, $sformatf("rw2_wait%0d", i));
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, ERRS, "rw2_err");
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
